sort_sequencer: RTL

//   Multi-cycle controller for the SORT instruction: bubble-sorts LEN consecutive

---
 rtl/sort_sequencer_pkg.sv | 17 +
 rtl/sort_cmp_swap.sv | 50 +++++
 rtl/sort_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sort_sequencer_pkg.sv
// Shared definitions for the SORT instruction sequencer.
//   SORT_DATA_W / SORT_ADDR_W : default register width and register index width
//   sort_state_t              : sequencer FSM states
package sort_sequencer_pkg;

    localparam int unsigned SORT_DATA_W = 32;
    localparam int unsigned SORT_ADDR_W = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMP     = 3'd1,
        S_SWAP_LO = 3'd2,
        S_SWAP_HI = 3'd3,
        S_DONE    = 3'd4
    } sort_state_t;

endpackage

// File: rtl/sort_cmp_swap.sv
// Signed comparator plus pair latch used by the SORT sequencer.
// Ports:
//   clk, rst      clock; synchronous active-low reset
//   latch_en      capture the current pair (d1 -> d_hi, d2 -> d_lo)
//   d1, d2        register-file read data for elements j and j+1
//   gt_c          combinational: $signed(d1) > $signed(d2)
//   d_lo, d_hi    latched pair; d_lo is written to the lower index, d_hi to the upper
module sort_cmp_swap
    import sort_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = SORT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              latch_en,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    output logic              gt_c,
    output logic [DATA_W-1:0] d_lo,
    output logic [DATA_W-1:0] d_hi
);

    logic [DATA_W-1:0] d_lo_q, d_lo_d;
    logic [DATA_W-1:0] d_hi_q, d_hi_d;

    // Compare and next-value selection for the pair latch
    always_comb begin
        gt_c   = $signed(d1) > $signed(d2);
        d_lo_d = d_lo_q;
        d_hi_d = d_hi_q;
        if (latch_en) begin
            d_lo_d = d2;
            d_hi_d = d1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_lo_q <= '0;
            d_hi_q <= '0;
        end else begin
            d_lo_q <= d_lo_d;
            d_hi_q <= d_hi_d;
        end
    end

    assign d_lo = d_lo_q;
    assign d_hi = d_hi_q;

endmodule

// File: rtl/sort_sequencer.sv
// Multi-cycle SORT controller: bubble-sorts len register-file entries starting at
// base_reg in place, ascending, signed compare. Borrows the register-file ports
// while busy; index arithmetic wraps mod 2**ADDR_W.
// Optional feature macro: SORT_EARLY_EXIT_EN -- stop after the first pass that
// performs no swap. Without it, exactly len-1 passes always run.
// Ports:
//   clk, rst                   clock; synchronous active-low reset (aborts a sort)
//   start, base_reg, len       request from ID, sampled only in IDLE
//   rf_rd_addr1/2, rf_rd_data1/2  pair read (elements j and j+1), data combinational
//   wb_wr_en                   WB stage owns the write port this cycle
//   rf_wr_en/addr/data         swap write-back
//   busy                       state != IDLE, feeds the hazard unit
//   done                       one-cycle completion pulse
module sort_sequencer
    import sort_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = SORT_DATA_W,
    parameter int unsigned ADDR_W = SORT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_reg,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] rf_rd_addr1,
    output logic [ADDR_W-1:0] rf_rd_addr2,
    input  logic [DATA_W-1:0] rf_rd_data1,
    input  logic [DATA_W-1:0] rf_rd_data2,
    input  logic              wb_wr_en,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              busy,
    output logic              done
);

`ifdef SORT_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    sort_state_t       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic [ADDR_W-1:0] pass_q, pass_d;
    logic              swapped_q, swapped_d;

    logic [ADDR_W-1:0] pair_lo, pair_hi;
    logic [ADDR_W-1:0] j_inc, pass_inc, pass_last, j_last;
    logic              gt_c, latch_en, advance;
    logic [DATA_W-1:0] d_lo, d_hi;

    sort_cmp_swap #(
        .DATA_W (DATA_W)
    ) u_cmp_swap (
        .clk      (clk),
        .rst      (rst),
        .latch_en (latch_en),
        .d1       (rf_rd_data1),
        .d2       (rf_rd_data2),
        .gt_c     (gt_c),
        .d_lo     (d_lo),
        .d_hi     (d_hi)
    );

    // Pair indices and loop bounds; the last j of a pass is len-2-pass
    always_comb begin
        pair_lo   = base_q + j_q;
        pair_hi   = pair_lo + ADDR_W'(1);
        j_inc     = j_q + ADDR_W'(1);
        pass_inc  = pass_q + ADDR_W'(1);
        pass_last = len_q - ADDR_W'(1);
        j_last    = pass_last - pass_q;
    end

    // Next-state, counters and port drive
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        j_d         = j_q;
        pass_d      = pass_q;
        swapped_d   = swapped_q;
        latch_en    = 1'b0;
        advance     = 1'b0;
        rf_rd_addr1 = '0;
        rf_rd_addr2 = '0;
        rf_wr_en    = 1'b0;
        rf_wr_addr  = '0;
        rf_wr_data  = '0;
        busy        = (state_q != S_IDLE);
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d    = base_reg;
                    len_d     = len;
                    j_d       = '0;
                    pass_d    = '0;
                    swapped_d = 1'b0;
                    state_d   = (len < ADDR_W'(2)) ? S_DONE : S_CMP;
                end
            end
            S_CMP: begin
                rf_rd_addr1 = pair_lo;
                rf_rd_addr2 = pair_hi;
                if (gt_c) begin
                    latch_en  = 1'b1;
                    swapped_d = 1'b1;
                    state_d   = S_SWAP_LO;
                end else begin
                    advance = 1'b1;
                end
            end
            S_SWAP_LO: begin
                rf_rd_addr1 = pair_lo;
                rf_rd_addr2 = pair_hi;
                // WB owns the write port: hold and retry
                if (!wb_wr_en) begin
                    rf_wr_en   = 1'b1;
                    rf_wr_addr = pair_lo;
                    rf_wr_data = d_lo;
                    state_d    = S_SWAP_HI;
                end
            end
            S_SWAP_HI: begin
                rf_rd_addr1 = pair_lo;
                rf_rd_addr2 = pair_hi;
                if (!wb_wr_en) begin
                    rf_wr_en   = 1'b1;
                    rf_wr_addr = pair_hi;
                    rf_wr_data = d_hi;
                    advance    = 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Step to the next pair; at the end of a pass start the next pass or finish
        if (advance) begin
            if (j_inc == j_last) begin
                j_d       = '0;
                pass_d    = pass_inc;
                swapped_d = 1'b0;
                if ((pass_inc == pass_last) || (EARLY_EXIT && !swapped_q)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CMP;
                end
            end else begin
                j_d     = j_inc;
                state_d = S_CMP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            j_q       <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            j_q       <= j_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
        end
    end

endmodule
